// File: rtl/jit_write_arbiter.sv
// Round-robin arbiter sharing one code-buffer write unit among NUM_REQ JIT requesters.
// Define WRITE_ARB_WRAP_EN for a circular buffer (no full flag, no word counter).
module jit_write_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          wr_start,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [ADDRESS_WIDTH-1:0]      wr_addr,
  input  logic                          wr_ready,
  output logic                          busy,
  output logic                          full
);

  localparam int LGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = LGW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                   state_q, state_d;
  logic [LGW-1:0]           last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                     full_w;
  logic                     xfer_done;

  logic [SW-1:0]            scan_start;
  logic [SW-1:0]            unrot_shift;
  logic [NUM_REQ-1:0]       req_rot, pick_rot, pick;
  logic [LGW-1:0]           pick_idx;
  logic [DATA_WIDTH-1:0]    pick_data;
  logic                     any_pick;

  assign xfer_done = (state_q == ISSUE) && wr_ready;

  // Rotate req so the slot after last_grant sits at bit 0, take the lowest
  // set bit, then rotate the one-hot pick back into requester order.
  always_comb begin
    scan_start = SW'(last_grant_q) + SW'(1);
    if (scan_start >= SW'(NUM_REQ)) scan_start = '0;
    unrot_shift = SW'(NUM_REQ) - scan_start;
    req_rot  = NUM_REQ'({req, req} >> scan_start);
    pick_rot = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req_rot[k] && (pick_rot == '0)) pick_rot[k] = 1'b1;
    end
    pick      = NUM_REQ'({pick_rot, pick_rot} >> unrot_shift);
    any_pick  = |pick_rot;
    pick_idx  = '0;
    pick_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (pick[j]) begin
        pick_idx  = LGW'(j);
        pick_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = '0;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    unique case (state_q)
      IDLE: begin
        if (any_pick && !full_w) begin
          state_d      = ISSUE;
          last_grant_d = pick_idx;
          grant_d      = pick;
          wr_data_d    = pick_data;
        end
      end
      ISSUE: begin
        if (wr_ready) begin
          state_d   = IDLE;
          wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= LGW'(NUM_REQ - 1);
      grant_q      <= '0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

`ifdef WRITE_ARB_WRAP_EN
  assign full_w = 1'b0;
  assign full   = 1'b0;
`else
  logic [ADDRESS_WIDTH:0] count_q, count_d;
  logic                   full_q, full_d;

  // Count cannot pass capacity: no grant is issued once full is set.
  always_comb begin
    count_d = count_q;
    if (xfer_done) count_d = count_q + (ADDRESS_WIDTH+1)'(1);
    full_d = count_d[ADDRESS_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign full_w = full_q;
  assign full   = full_q;
`endif

  assign grant    = grant_q;
  assign wr_start = (state_q == ISSUE);
  assign busy     = (state_q == ISSUE);
  assign wr_data  = wr_data_q;
  assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_jit_write_arbiter.sv
// Scoreboard bench for jit_write_arbiter: transaction-level model plus per-cycle monitor.
module tb_jit_write_arbiter;
  localparam int NR    = 2;
  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic             clk, reset, wr_ready, wr_start, busy, full;
  logic [NR-1:0]    req, grant;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    wr_data;
  logic [AW-1:0]    wr_addr;

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            addr;
  } wr_t;

  wr_t           wq[$];
  logic [NR-1:0] gq[$];
  bit            m_busy, m_full;
  int            m_last, m_addr, m_cnt;

  jit_write_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .wr_start(wr_start),
    .wr_data(wr_data),
    .wr_addr(wr_addr),
    .wr_ready(wr_ready),
    .busy(busy),
    .full(full)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Reference: one word in flight at a time; winner is the first requester
  // after the previous winner in circular order; nothing granted once full.
  always @(posedge clk) begin
    int win;
    logic [NR-1:0] g;
    if (!reset) begin
      m_busy = 0; m_full = 0; m_last = NR - 1; m_addr = 0; m_cnt = 0;
      gq.delete(); wq.delete();
    end else if (m_busy) begin
      if (wr_ready) begin
        m_busy = 0;
        wq.delete(0);
        m_addr = (m_addr + 1) % DEPTH;
        m_cnt++;
`ifndef WRITE_ARB_WRAP_EN
        if (m_cnt == DEPTH) m_full = 1;
`endif
      end
    end else if (!m_full && req != '0) begin
      win = -1;
      for (int k = 1; k <= NR; k++) begin
        if (win < 0 && req[(m_last + k) % NR]) win = (m_last + k) % NR;
      end
      m_last = win;
      m_busy = 1;
      g = '0;
      g[win] = 1'b1;
      gq.push_back(g);
      wq.push_back('{req_data[win*DW +: DW], m_addr});
    end
  end

  always @(negedge clk) begin
    logic [NR-1:0] exp_g;
    if (mon_en) begin
      exp_g = (gq.size() > 0) ? gq.pop_front() : '0;
      chk("grant", grant, exp_g);
      chk("wr_start", wr_start, m_busy);
      chk("busy", busy, m_busy);
      chk("wr_addr", wr_addr, m_addr);
      chk("full", full, m_full);
      if (wr_start && wq.size() > 0) chk("wr_data", wr_data, wq[0].data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  initial begin
    reset = 0; req = '0; req_data = '0; wr_ready = 0;
    tick(); tick();
    reset = 1;
    chk("rst_grant", grant, 0);
    chk("rst_wr_start", wr_start, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    mon_en = 1;

    // single request, wr_ready two cycles after start
    req = 2'b01; req_data[DW-1:0] = 32'h0000_00A5;
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_data", wr_data, 32'hA5);
    req = '0;
    tick(); tick();
    chk("t1_start3", wr_start, 1);
    wr_ready = 1;
    tick();
    wr_ready = 0;
    chk("t1_addr", wr_addr, 1);
    chk("t1_start_off", wr_start, 0);

    // both requesting continuously, wr_ready tied high
    do_reset();
    req = 2'b11; wr_ready = 1;
    req_data = {32'h1111_0001, 32'h0000_0000};
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int i = 0; i < NR; i++) if (grant[i]) req_data[i*DW +: DW] = $urandom;
    end
    req = '0; wr_ready = 0;

    // reset during ISSUE
    do_reset();
    req = 2'b10;
    tick();
    req = '0;
    tick();
    reset = 0;
    tick();
    reset = 1;
    chk("t3_start", wr_start, 0);
    chk("t3_addr", wr_addr, 0);
    chk("t3_grant", grant, 0);
    req = 2'b11;
    tick();
    chk("t3_first", grant, 2'b01);
    req = '0; wr_ready = 1;
    tick();
    wr_ready = 0;

    // req[1] pulsed only while serving req[0]
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b10;
    tick();
    req = '0; wr_ready = 1;
    tick();
    wr_ready = 0;
    tick(); tick();

    // wr_ready pulsed while idle
    wr_ready = 1;
    tick();
    wr_ready = 0;
    tick();
    chk("t6_addr", wr_addr, 1);

    // fill the buffer from one requester
    do_reset();
    req = 2'b01; wr_ready = 1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (grant[0]) req_data[DW-1:0] = $urandom;
    end
`ifdef WRITE_ARB_WRAP_EN
    chk("t4_full", full, 0);
`else
    chk("t4_full", full, 1);
`endif
    chk("t4_start", wr_start, 0);
    req = '0; wr_ready = 0;

    // randomized traffic with occasional resets
    for (int c = 0; c < 700; c++) begin
      tick();
      reset = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < NR; i++) begin
        if (grant[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          req_data[i*DW +: DW] = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      wr_ready = $urandom_range(0, 1);
    end
    reset = 1; req = '0; wr_ready = 0;
    tick(); tick();
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jit_write_arbiter.md
Name: jit_write_arbiter

Overview:
Shares the single 32-bit code-buffer write unit (start/ready/data handshake, ADDRESS_WIDTH-bit word addressing) between up to four JIT requesters, e.g. the bytecode translator and the branch patcher.
Each requester presents one word at a time. The arbiter picks requesters round-robin, latches the word, drives the write unit's start/data, and tracks the next code-buffer word address.
It stops granting when the buffer is full.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
DATA_WIDTH, 32, word width passed to the write unit
ADDRESS_WIDTH, 8, code-buffer word address width; capacity is 2**ADDRESS_WIDTH words

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising edge of clk
req  in  NUM_REQ  per-requester request; held with its data until that requester's grant
req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  NUM_REQ  one-hot, one-cycle pulse: requester's word captured
wr_start  out  1  start to write unit; held high until wr_ready sampled high
wr_data  out  DATA_WIDTH  latched word, stable while wr_start high
wr_addr  out  ADDRESS_WIDTH  address of the word currently or next issued
wr_ready  in  1  write unit completion; transfer completes on any edge with wr_start=1 and wr_ready=1
busy  out  1  high in ISSUE
full  out  1  high once 2**ADDRESS_WIDTH words are written

Behaviour:
- Reset (reset=0 at edge): state IDLE; grant=0, wr_start=0, wr_data=0, wr_addr=0, busy=0, full=0; word count=0; last_grant=NUM_REQ-1, so req[0] has first priority.
- Reset mid-transfer: wr_start drops the cycle after the reset edge. The in-flight word is discarded with no grant re-issue. Requesters are responsible for re-presenting it.
- States: IDLE, ISSUE.
- IDLE, with any req bit high and full=0:
  - Select the first set bit scanning from last_grant+1, modulo NUM_REQ.
  - At the edge: latch its data into wr_data, set last_grant, pulse grant[sel] for exactly the next cycle, go to ISSUE.
- IDLE otherwise: stay; all outputs hold; grant=0.
- ISSUE:
  - wr_start=1 and busy=1.
  - Edge with wr_ready=1: transfer done; wr_addr+1, count+1, go to IDLE. wr_start=0 next cycle.
  - Edge with wr_ready=0: stay in ISSUE.
- Latency: req sampled at edge N gives grant and wr_start high in cycle N+1.
- Minimum spacing: 2 cycles per word (ISSUE, IDLE).
- req/req_data are ignored outside IDLE sampling. A requester must update or drop req after seeing grant; it has at least one ISSUE cycle to do so.
- Count is ADDRESS_WIDTH+1 bits. full=1 from the cycle after count reaches 2**ADDRESS_WIDTH. wr_addr then reads 0 (wrapped bits) but no further grant or wr_start is issued until reset.
- Simultaneous requests with no prior grant: lowest index wins. Afterwards, strict rotation among active requesters.
- A req deasserting before grant is legal; no grant is issued to it.
- wr_ready high while in IDLE is ignored.

Optional Feature:
WRITE_ARB_WRAP_EN.
- Defined: the code buffer is circular. wr_addr wraps from 2**ADDRESS_WIDTH-1 to 0 and continues granting; full is tied 0; the count register is omitted.
- Undefined: full behaviour exactly as above; no grants after capacity is reached.

Test Plan:
- Reset then single request: req=01, req_data[0]=0x0000_00A5, wr_ready returns 2 cycles after wr_start -> grant=01 for 1 cycle; wr_data=0xA5 at wr_addr=0; wr_start high 3 cycles; wr_addr=1 afterwards.
- Both requesting continuously with changing words, wr_ready tied 1 -> grants alternate 01,10,01,10; wr_addr 0,1,2,3; one word per 2 cycles.
- Reset asserted (0) during ISSUE with wr_ready=0 -> next cycle wr_start=0, wr_addr=0, grant=0; the next request goes to req[0] first.
- ADDRESS_WIDTH=2, one requester, 4 words written -> full=1 after the 4th completion; the 5th request gets no grant and wr_start stays 0. With WRITE_ARB_WRAP_EN the 5th word is written at wr_addr=0 and full stays 0.
- req[1] pulsed high one cycle while in ISSUE serving req[0], then low -> no grant to requester 1 ever.
- wr_ready pulsed while IDLE with no requests -> no state change; wr_addr unchanged.
